// File: rtl/pixel_stream_filter.sv
// Streaming pixel filter: pass / negative / grayscale / threshold, selected per frame,
// with a fixed 2-cycle output latency after the accepting edge and frame-boundary tagging.
module pixel_stream_filter #(
  parameter int CH           = 3,
  parameter int CW           = 8,
  parameter int FRAME_PIXELS = 65536,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*CW-1:0]    pixel_in,
  input  logic                in_valid,
  input  logic [1:0]          mode,
  input  logic [CW-1:0]       thresh,
  output logic [CH*CW-1:0]    pixel_out,
  output logic                valid,
  output logic                frame_done,
  output logic [CNT_W-1:0]    pixel_cnt
);

  localparam int PW = CH * CW;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_NEG    = 2'd1,
    MODE_GRAY   = 2'd2,
    MODE_THRESH = 2'd3
  } mode_t;

  // Frame position and per-frame settings
  mode_t             mode_q;
  logic [CW-1:0]     thresh_q;
  logic              first_px;
  logic              last_px;
  mode_t             eff_mode;
  logic [CW-1:0]     eff_thresh;

  assign first_px   = (pixel_cnt == '0);
  assign last_px    = (pixel_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign eff_mode   = first_px ? mode_t'(mode) : mode_q;
  assign eff_thresh = first_px ? thresh : thresh_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_cnt <= '0;
      mode_q    <= MODE_PASS;
      thresh_q  <= '0;
    end else if (in_valid) begin
      pixel_cnt <= last_px ? '0 : pixel_cnt + CNT_W'(1);
      if (first_px) begin
        mode_q   <= mode_t'(mode);
        thresh_q <= thresh;
      end
    end
  end

  // Stage 0: registered input, tagged with the mode/thresh in force for this pixel
  logic              s0_valid;
  logic [PW-1:0]     s0_px;
  mode_t             s0_mode;
  logic [CW-1:0]     s0_thresh;
  logic              s0_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_valid  <= 1'b0;
      s0_px     <= '0;
      s0_mode   <= MODE_PASS;
      s0_thresh <= '0;
      s0_last   <= 1'b0;
    end else begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_px     <= pixel_in;
        s0_mode   <= eff_mode;
        s0_thresh <= eff_thresh;
        s0_last   <= last_px;
      end
    end
  end

  // Stage 1: per-channel arithmetic and luminance estimate
  logic [CW-1:0]     gray_d;
  logic [PW-1:0]     s1_px_d;

  generate
    if (CH == 3) begin : g_gray_rgb
      logic [CW+1:0] sum;
      // c2 + 2*c1 + c0 needs two extra bits; the shifted result always fits CW bits
      assign sum    = {2'b00, s0_px[2*CW +: CW]}
                    + {1'b0, s0_px[CW +: CW], 1'b0}
                    + {2'b00, s0_px[0 +: CW]};
      assign gray_d = sum[CW+1:2];
    end else begin : g_gray_ch0
      assign gray_d = s0_px[CW-1:0];
    end
  endgenerate

  always_comb begin
    s1_px_d = s0_px;
    if (s0_mode == MODE_NEG) begin
      s1_px_d = ~s0_px;
    end
  end

  logic              s1_valid;
  logic [PW-1:0]     s1_px;
  logic [CW-1:0]     s1_gray;
  mode_t             s1_mode;
  logic [CW-1:0]     s1_thresh;
  logic              s1_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_px     <= '0;
      s1_gray   <= '0;
      s1_mode   <= MODE_PASS;
      s1_thresh <= '0;
      s1_last   <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_px     <= s1_px_d;
        s1_gray   <= gray_d;
        s1_mode   <= s0_mode;
        s1_thresh <= s0_thresh;
        s1_last   <= s0_last;
      end
    end
  end

  // Stage 2: channel replication / binarisation, output register
  logic [PW-1:0]     out_d;

  always_comb begin
    out_d = s1_px;
    case (s1_mode)
      MODE_GRAY:   out_d = {CH{s1_gray}};
      MODE_THRESH: out_d = (s1_gray >= s1_thresh) ? '1 : '0;
      default:     out_d = s1_px;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_out  <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid      <= s1_valid;
      frame_done <= s1_valid & s1_last;
      if (s1_valid) begin
        pixel_out <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_filter.sv
// Self-checking bench for pixel_stream_filter: directed vector table plus a
// cycle-accurate scoreboard fed from an independent reference model.
module tb_pixel_stream_filter;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int FP = 4;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [23:0]       pixel_in;
  logic              in_valid;
  logic [1:0]        mode;
  logic [7:0]        thresh;
  logic [23:0]       pixel_out;
  logic              valid;
  logic              frame_done;
  logic [CNT_W-1:0]  pixel_cnt;

  pixel_stream_filter #(
    .CH(CH), .CW(CW), .FRAME_PIXELS(FP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid),
    .mode(mode), .thresh(thresh), .pixel_out(pixel_out), .valid(valid),
    .frame_done(frame_done), .pixel_cnt(pixel_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_px(input logic [1:0] md, input logic [7:0] th,
                                           input logic [23:0] p);
    int unsigned gray;
    logic [7:0]  g8;
    gray = p[23:16] + 2 * p[15:8] + p[7:0];
    gray = gray >> 2;
    g8   = gray[7:0];
    case (md)
      2'd0:    return p;
      2'd1:    return 24'hFFFFFF - p;
      2'd2:    return {g8, g8, g8};
      default: return (g8 >= th) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  typedef struct {
    logic [23:0] data;
    logic        fd;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned m_cnt = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [7:0]  m_th = 8'd0;
  logic        mon_on = 1'b0;
  int          fd_seen = 0;

  // Reference model: acceptance, frame counter, per-frame mode latch
  always @(posedge clk) begin : model
    exp_t e;
    cyc++;
    if (rst === 1'b0) begin
      sb.delete();
      m_cnt  = 0;
      m_mode = 2'd0;
      m_th   = 8'd0;
    end else if (in_valid === 1'b1) begin
      if (m_cnt == 0) begin
        m_mode = mode;
        m_th   = thresh;
      end
      e.data = model_px(m_mode, m_th, pixel_in);
      e.fd   = (m_cnt == FP - 1);
      e.due  = cyc + 2;
      sb.push_back(e);
      m_cnt = (m_cnt == FP - 1) ? 0 : m_cnt + 1;
    end
  end

  // Output monitor, sampling on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_on) begin
      check("pixel_cnt", 32'(pixel_cnt), m_cnt);
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got valid=1 expected valid=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("sb_data", 32'(pixel_out), 32'(e.data));
          check("sb_frame_done", 32'(frame_done), 32'(e.fd));
          check("sb_latency_cycle", cyc, e.due);
          if (frame_done === 1'b1) fd_seen++;
        end
      end else begin
        check("valid_known", 32'(valid), 32'd0);
        check("frame_done_idle", 32'(frame_done), 32'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_output: got valid=0 expected valid=1 data %h at %0t",
                   sb[0].data, $time);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [23:0] p, input logic [1:0] md,
                       input logic [7:0] th);
    @(posedge clk);
    #1;
    in_valid = v;
    pixel_in = p;
    mode     = md;
    thresh   = th;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [7:0]  th;
    logic [23:0] px;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[10];
  int   fd_before;
  bit   got;

  initial begin
    tbl[0] = '{2'd1, 8'h00, 24'h123456, 24'hEDCBA9};
    tbl[1] = '{2'd2, 8'h00, 24'hFF0000, 24'h3F3F3F};
    tbl[2] = '{2'd2, 8'h00, 24'h00FF00, 24'h7F7F7F};
    tbl[3] = '{2'd3, 8'h80, 24'h808080, 24'hFFFFFF};
    tbl[4] = '{2'd3, 8'h80, 24'h7F7F7F, 24'h000000};
    tbl[5] = '{2'd0, 8'h00, 24'hA5C3E1, 24'hA5C3E1};
    tbl[6] = '{2'd2, 8'h00, 24'hFFFFFF, 24'hFFFFFF};
    tbl[7] = '{2'd3, 8'h00, 24'h000000, 24'hFFFFFF};
    tbl[8] = '{2'd3, 8'hFF, 24'hFEFEFE, 24'h000000};
    tbl[9] = '{2'd2, 8'h00, 24'h010203, 24'h020202};

    rst = 1'b0; in_valid = 1'b0; pixel_in = '0; mode = '0; thresh = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_on = 1'b1;

    // Reset state
    reset_dut();
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pixel_cnt", 32'(pixel_cnt), 32'd0);

    // Single-pixel vectors, each starting a fresh frame
    for (int i = 0; i < 10; i++) begin
      reset_dut();
      drive(1'b1, tbl[i].px, tbl[i].md, tbl[i].th);
      drive(1'b0, 24'h0, 2'd0, 8'h0);
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (valid === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      check("tbl_valid_seen", 32'(got), 32'd1);
      check("tbl_data", 32'(pixel_out), 32'(tbl[i].exp));
      @(negedge clk);
      check("tbl_single_pulse", 32'(valid), 32'd0);
    end

    // Back-to-back grayscale and threshold pairs
    reset_dut();
    drive(1'b1, 24'hFF0000, 2'd2, 8'h00);
    drive(1'b1, 24'h00FF00, 2'd2, 8'h00);
    drive(1'b0, 24'h0, 2'd2, 8'h00);
    repeat (4) @(posedge clk);
    reset_dut();
    drive(1'b1, 24'h808080, 2'd3, 8'h80);
    drive(1'b1, 24'h7F7F7F, 2'd3, 8'h80);
    drive(1'b0, 24'h0, 2'd3, 8'h80);
    repeat (4) @(posedge clk);

    // Frame boundary: mode changes mid-frame take effect at the next frame
    reset_dut();
    fd_before = fd_seen;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 24'h102030 + 24'(i * 24'h050403), (i >= 2) ? 2'd0 : 2'd1, 8'h00);
    end
    drive(1'b0, 24'h0, 2'd0, 8'h00);
    repeat (4) @(posedge clk);
    check("frame_done_pulses", 32'(fd_seen - fd_before), 32'd2);

    // Gapped input
    reset_dut();
    drive(1'b1, 24'h0A0B0C, 2'd1, 8'h00);
    drive(1'b0, 24'hFFFFFF, 2'd1, 8'h00);
    drive(1'b1, 24'h0D0E0F, 2'd1, 8'h00);
    drive(1'b0, 24'h0, 2'd1, 8'h00);
    check("gap_pixel_cnt", 32'(pixel_cnt), 32'd2);
    repeat (4) @(posedge clk);

    // Reset with two pixels in flight
    reset_dut();
    drive(1'b1, 24'h111111, 2'd1, 8'h00);
    drive(1'b1, 24'h222222, 2'd1, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_pixel_cnt", 32'(pixel_cnt), 32'd0);
    repeat (3) @(posedge clk);
    drive(1'b1, 24'h123456, 2'd0, 8'h00);
    drive(1'b0, 24'h0, 2'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_next_valid", 32'(valid), 32'd1);
    check("midrst_next_pass", 32'(pixel_out), 32'h123456);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
